// File: rtl/seq_shift_add_mul_pkg.sv
// rtl/seq_shift_add_mul_pkg.sv - shared state encodings and sizing helpers for the iterative multiplier
package seq_shift_add_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// rtl/seq_shift_add_mul.sv - radix-2 shift-add multiplier, one multiplier bit per clock
module seq_shift_add_mul
    import seq_shift_add_mul_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH-1:0]   mult_q;
    logic               neg_q;
    logic               done_q;
    logic               busy_q;

    logic [WIDTH-1:0]   mag_a_d;
    logic [WIDTH-1:0]   mag_b_d;
    logic [WIDTH-1:0]   mult_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] product_d;
    logic               neg_d;
    logic               run_last_d;

    // The most-negative operand negates to itself, which read unsigned is exactly 2^(W-1).
    always_comb begin
        mag_a_d    = (Signed && A[WIDTH-1]) ? -A : A;
        mag_b_d    = (Signed && B[WIDTH-1]) ? -B : B;
        neg_d      = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
        mult_d     = mult_q >> 1;
        acc_d      = mult_q[0] ? (acc_q + mcand_q) : acc_q;
        run_last_d = (cnt_q == CNT_LAST) || (EARLY_EXIT && (mult_d == '0));
        product_d  = neg_q ? -acc_q : acc_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            mult_q    <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    // The Done cycle is still part of the previous operation, so Start is refused there.
                    if (Start && !done_q) begin
                        mcand_q <= {{WIDTH{1'b0}}, mag_a_d};
                        mult_q  <= mag_b_d;
                        neg_q   <= neg_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    mult_q  <= mult_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (run_last_d) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    product_q <= product_d;
                    done_q    <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb/tb_seq_shift_add_mul.sv - directed checks of seq_shift_add_mul with and without early exit
module tb_seq_shift_add_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy_e, done_e, busy_f, done_f;
    logic [63:0] prod_e, prod_f;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_shift_add_mul #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut_e (
        .CLK(clk), .RST(rst), .Start(start), .Signed(sgn), .A(a), .B(b),
        .Busy(busy_e), .Done(done_e), .Product(prod_e)
    );

    seq_shift_add_mul #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_f (
        .CLK(clk), .RST(rst), .Start(start), .Signed(sgn), .A(a), .B(b),
        .Busy(busy_f), .Done(done_f), .Product(prod_f)
    );

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; Start is sampled at the next rising edge (edge 0).
    task automatic run_op(input string tag, input bit sg, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp_p, input int exp_de, input int exp_df,
                          input bit poke_mid, input bit poke_done);
        int de = 0;
        int df = 0;
        bit seq_ok = 1'b1;
        sgn   = sg;
        a     = av;
        b     = bv;
        start = 1'b1;
        for (int c = 1; c <= 80 && (de == 0 || df == 0); c++) begin
            @(negedge clk);
            start = 1'b0;
            a     = $urandom;
            b     = $urandom;
            sgn   = 1'($urandom_range(0, 1));
            if (poke_mid && c == 2) begin
                start = 1'b1;
                a     = 32'd99;
                b     = 32'd99;
            end
            if (de == 0 && done_e) begin
                de = c;
                if (poke_done) begin
                    start = 1'b1;
                    a     = 32'd5;
                    b     = 32'd5;
                end
            end
            if (df == 0 && done_f) df = c;
            if (busy_e !== ((de == 0 || c <= de) ? 1'b1 : 1'b0)) seq_ok = 1'b0;
            if (busy_f !== ((df == 0 || c <= df) ? 1'b1 : 1'b0)) seq_ok = 1'b0;
            if (de != 0 && c > de && done_e) seq_ok = 1'b0;
            if (df != 0 && c > df && done_f) seq_ok = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        check64({tag, "_done_cycle_ee1"}, 64'(de), 64'(exp_de));
        check64({tag, "_done_cycle_ee0"}, 64'(df), 64'(exp_df));
        check64({tag, "_product_ee1"}, prod_e, exp_p);
        check64({tag, "_product_ee0"}, prod_f, exp_p);
        check64({tag, "_busy_done_shape"}, 64'(seq_ok), 64'd1);
        check64({tag, "_idle_after"}, {60'd0, busy_e, done_e, busy_f, done_f}, 64'd0);
    endtask

    initial begin
        logic signed [63:0] sa, sb;
        logic [31:0]        ra, rb, mb;
        logic [63:0]        rp;
        bit                 rs;
        int                 rn;

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        check64("reset_flags", {60'd0, busy_e, done_e, busy_f, done_f}, 64'd0);
        check64("reset_product_ee1", prod_e, 64'd0);
        check64("reset_product_ee0", prod_f, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("u_7x6",      1'b0, 32'd7,          32'd6,          64'h0000_0000_0000_002A,  5, 34, 1'b0, 1'b0);
        run_op("u_max_sq",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 34, 34, 1'b0, 1'b0);
        run_op("s_m3x5",     1'b1, 32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1,  5, 34, 1'b0, 1'b0);
        run_op("s_minsq",    1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 34, 34, 1'b0, 1'b0);
        run_op("u_bzero",    1'b0, 32'h0000_1234,  32'd0,          64'd0,                    3, 34, 1'b0, 1'b1);
        run_op("u_midstart", 1'b0, 32'h0000_0010,  32'h0000_0100,  64'h0000_0000_0000_1000, 11, 34, 1'b1, 1'b0);
        run_op("s_5xm1",     1'b1, 32'd5,          32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFB,  3, 34, 1'b0, 1'b0);
        run_op("s_m7xm9",    1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFF7,  64'h0000_0000_0000_003F,  6, 34, 1'b0, 1'b0);
        run_op("u_msbx2",    1'b0, 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000,  4, 34, 1'b0, 1'b0);

        sgn   = 1'b0;
        a     = 32'h0000_FFFF;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check64("midrun_rst_flags", {60'd0, busy_e, done_e, busy_f, done_f}, 64'd0);
        check64("midrun_rst_product_ee1", prod_e, 64'd0);
        check64("midrun_rst_product_ee0", prod_f, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check64("post_rst_idle", {60'd0, busy_e, done_e, busy_f, done_f}, 64'd0);
        run_op("u_12x13", 1'b0, 32'd12, 32'd13, 64'h0000_0000_0000_009C, 6, 34, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i[0]) rb = -rb;
            if (rs) begin
                sa = {{32{ra[31]}}, ra};
                sb = {{32{rb[31]}}, rb};
                rp = sa * sb;
            end else begin
                rp = {32'd0, ra} * {32'd0, rb};
            end
            mb = (rs && rb[31]) ? -rb : rb;
            rn = 1;
            for (int k = 0; k < 32; k++) if (mb[k]) rn = k + 1;
            run_op($sformatf("rnd%0d", i), rs, ra, rb, rp, rn + 2, 34, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
